// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and the data memory (slave).
// Address is word aligned; byte lanes are selected with mem_be.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Issues one bus transaction per aligned access
// and stalls the pipeline until it completes or times out. A misaligned word
// access raises AlignFault without touching the bus. Loads update ReadData;
// stores leave it untouched.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemReqM,
    input  logic                    MemWriteM,
    input  logic                    MByteM,
    input  logic [31:0]             ALUOutM,
    input  logic [31:0]             WriteDataM,
    load_store_unit_if.master       bus,
    output logic [31:0]             ReadData,
    output logic                    StallM,
    output logic                    MemDone,
    output logic                    AlignFault,
    output logic                    BusFault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count value held in the last permitted REQ cycle before abort.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        aligned;
    logic        issue;
    logic        complete;
    logic        expire;

    logic        we_q;
    logic        byte_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt_q;
    logic        ok_q;
    logic [31:0] rdata_q;
    logic [7:0]  lane;

    assign aligned = MByteM | (ALUOutM[1:0] == 2'b00);

    // Byte lane selected by the low address bits of the held access.
    assign lane = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];

    // Bus outputs come only from registers captured at issue time.
    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign ReadData      = rdata_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle control/status outputs.
    always_comb begin
        state_d    = state_q;
        StallM     = 1'b0;
        AlignFault = 1'b0;
        MemDone    = 1'b0;
        BusFault   = 1'b0;
        issue      = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemReqM && !reset) begin
                    if (aligned) begin
                        state_d = REQ;
                        StallM  = 1'b1;
                        issue   = 1'b1;
                    end else begin
                        AlignFault = 1'b1;
                    end
                end
            end
            REQ: begin
                StallM = 1'b1;
                if (bus.mem_ack) begin
                    state_d  = DONE;
                    complete = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = DONE;
                    expire  = 1'b1;
                end
            end
            DONE: begin
                // The instruction is still presented here; it is not re-issued.
                state_d  = IDLE;
                MemDone  = ok_q;
                BusFault = ~ok_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Access capture, timeout counting and load result update.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 8'h0;
            ok_q    <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            if (issue) begin
                we_q    <= MemWriteM;
                byte_q  <= MByteM;
                addr_q  <= ALUOutM;
                be_q    <= MByteM ? (4'b0001 << ALUOutM[1:0]) : 4'b1111;
                wdata_q <= MByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
                cnt_q   <= 8'h0;
            end else if (state_q == REQ && !complete && !expire) begin
                cnt_q <= cnt_q + 8'h1;
            end
            if (complete) begin
                ok_q <= 1'b1;
                if (!we_q) begin
                    rdata_q <= byte_q ? {24'h0, lane} : bus.mem_rdata;
                end
            end
            if (expire) begin
                ok_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver pushes the hand-computed
// outcome of each access, the monitor pops it when the unit reports
// MemDone, BusFault or AlignFault.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        MemReqM;
    logic        MemWriteM;
    logic        MByteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadData;
    logic        StallM;
    logic        MemDone;
    logic        AlignFault;
    logic        BusFault;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .MByteM     (MByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .bus        (bus),
        .ReadData   (ReadData),
        .StallM     (StallM),
        .MemDone    (MemDone),
        .AlignFault (AlignFault),
        .BusFault   (BusFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind = {MemDone, BusFault, AlignFault}
    typedef struct {
        logic [2:0]  kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          reqc;
        int          stallc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-transaction observation of the bus and stall line.
    int          m_reqc = 0;
    int          m_stallc = 0;
    logic        m_inbus = 1'b0;
    logic        m_unstable = 1'b0;
    logic        c_we;
    logic [31:0] c_addr;
    logic [3:0]  c_be;
    logic [31:0] c_wdata;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            m_reqc = 0; m_stallc = 0; m_inbus = 1'b0; m_unstable = 1'b0;
        end else begin
            if (StallM) m_stallc++;
            if (bus.mem_req) begin
                m_reqc++;
                if (!m_inbus) begin
                    m_inbus = 1'b1;
                    c_we = bus.mem_we; c_addr = bus.mem_addr;
                    c_be = bus.mem_be; c_wdata = bus.mem_wdata;
                end else if (c_we !== bus.mem_we || c_addr !== bus.mem_addr ||
                             c_be !== bus.mem_be || c_wdata !== bus.mem_wdata) begin
                    m_unstable = 1'b1;
                end
            end
            if (MemDone || BusFault || AlignFault) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_event: got {done,bus,align}=%b expected none at %0t",
                             {MemDone, BusFault, AlignFault}, $time);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", {29'h0, MemDone, BusFault, AlignFault}, {29'h0, e.kind});
                    check("read_data", ReadData, e.rd);
                    check("req_cycles", m_reqc, e.reqc);
                    check("stall_cycles", m_stallc, e.stallc);
                    if (e.kind != 3'b001) begin
                        check("mem_we", {31'h0, c_we}, {31'h0, e.we});
                        check("mem_addr", c_addr, e.addr);
                        check("mem_be", {28'h0, c_be}, {28'h0, e.be});
                        check("mem_wdata", c_wdata, e.wdata);
                        check("bus_stable", {31'h0, m_unstable}, 32'h0);
                    end
                end
                m_reqc = 0; m_stallc = 0; m_inbus = 1'b0; m_unstable = 1'b0;
            end
        end
    end

    // Drive one access and act as memory; ack on REQ cycle ack_at (0 = never).
    task automatic run(input logic we, input logic byt, input logic [31:0] addr,
                       input logic [31:0] wd, input int ack_at, input logic [31:0] rdata,
                       input logic [2:0] kind, input logic [31:0] eaddr, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic [31:0] erd,
                       input int ereq, input int estall);
        exp_t e;
        int   reqn;
        logic fin;
        e.kind = kind; e.we = we; e.addr = eaddr; e.be = ebe; e.wdata = ewd;
        e.rd = erd; e.reqc = ereq; e.stallc = estall;
        sb.push_back(e);
        @(posedge clk); #1;
        MemReqM = 1'b1; MemWriteM = we; MByteM = byt; ALUOutM = addr; WriteDataM = wd;
        reqn = 0;
        fin = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (MemDone || BusFault || AlignFault) begin
                fin = 1'b1;
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req) begin
                reqn++;
                if (reqn == ack_at) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
                end else begin
                    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEAD0000 | 32'(reqn);
                end
            end
        end
        check("response_seen", {31'h0, fin}, 32'h1);
        @(posedge clk); #1;
        MemReqM = 1'b0; MemWriteM = 1'b0; MByteM = 1'b0; bus.mem_ack = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_req"}, {31'h0, bus.mem_req}, 32'h0);
        check({tag, "_mem_we"}, {31'h0, bus.mem_we}, 32'h0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_mem_be"}, {28'h0, bus.mem_be}, 32'h0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_ReadData"}, ReadData, 32'h0);
        check({tag, "_flags"}, {28'h0, StallM, MemDone, BusFault, AlignFault}, 32'h0);
    endtask

    initial begin
        int reqn;
        reset = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; MByteM = 1'b0;
        ALUOutM = 32'h0; WriteDataM = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("por");

        //  we byt addr          wdata         ack rdata         kind    eaddr         be       ewdata        ReadData      req stall
        run(0, 0, 32'h0000_0100, 32'h55AA55AA, 1,  32'hCAFEBABE, 3'b100, 32'h0000_0100, 4'b1111, 32'h55AA55AA, 32'hCAFEBABE, 1,  2);
        run(1, 1, 32'h0000_0203, 32'h123456AB, 1,  32'hFFFFFFFF, 3'b100, 32'h0000_0200, 4'b1000, 32'hABABABAB, 32'hCAFEBABE, 1,  2);
        run(0, 1, 32'h0000_0302, 32'h000000FF, 5,  32'h11223344, 3'b100, 32'h0000_0300, 4'b0100, 32'hFFFFFFFF, 32'h00000022, 5,  6);
        run(0, 0, 32'h0000_0101, 32'h0,        1,  32'h0,        3'b001, 32'h0,         4'b0000, 32'h0,        32'h00000022, 0,  0);
        run(0, 0, 32'h0000_0400, 32'h0,        0,  32'h0,        3'b010, 32'h0000_0400, 4'b1111, 32'h0,        32'h00000022, 16, 17);
        run(0, 0, 32'h0000_0404, 32'h0,        16, 32'h89ABCDEF, 3'b100, 32'h0000_0404, 4'b1111, 32'h0,        32'h89ABCDEF, 16, 17);
        run(1, 0, 32'h0000_0500, 32'h0BADF00D, 2,  32'h0,        3'b100, 32'h0000_0500, 4'b1111, 32'h0BADF00D, 32'h89ABCDEF, 2,  3);
        run(0, 1, 32'h0000_0601, 32'h0,        1,  32'h11223344, 3'b100, 32'h0000_0600, 4'b0010, 32'h0,        32'h00000033, 1,  2);
        run(0, 1, 32'h0000_0603, 32'h0,        1,  32'h11223344, 3'b100, 32'h0000_0600, 4'b1000, 32'h0,        32'h00000011, 1,  2);
        run(0, 1, 32'h0000_0600, 32'h0,        1,  32'hA1B2C3D4, 3'b100, 32'h0000_0600, 4'b0001, 32'h0,        32'h000000D4, 1,  2);
        run(1, 0, 32'h0000_0702, 32'h0,        1,  32'h0,        3'b001, 32'h0,         4'b0000, 32'h0,        32'h000000D4, 0,  0);

        // Reset on the third REQ cycle together with an ack: access is discarded.
        @(posedge clk); #1;
        MemReqM = 1'b1; MemWriteM = 1'b0; MByteM = 1'b0; ALUOutM = 32'h0000_0800;
        reqn = 0;
        for (int c = 0; c < 20 && reqn < 3; c++) begin
            @(negedge clk);
            if (bus.mem_req) reqn++;
        end
        check("reset_reached_req3", reqn, 3);
        reset = 1'b1; MemReqM = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check_reset_values("rst_req");
        reset = 1'b0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("late_ack_ReadData", ReadData, 32'h0);
        check("late_ack_mem_req", {31'h0, bus.mem_req}, 32'h0);
        @(negedge clk);
        check("late_ack_flags", {29'h0, MemDone, BusFault, StallM}, 32'h0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, default 16, max REQ cycles awaiting mem_ack before abort (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 MemReqM  input  1  memory-stage instruction performs a load/store.
REQ-005 MemWriteM  input  1  1 = store, 0 = load.
REQ-006 MByteM  input  1  1 = byte access, 0 = word access.
REQ-007 ALUOutM  input  32  byte address.
REQ-008 WriteDataM  input  32  store data.
REQ-009 mem_req  output  1  bus request, held until ack or timeout.
REQ-010 mem_we  output  1  bus write enable.
REQ-011 mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-012 mem_wdata  output  32  bus write data.
REQ-013 mem_be  output  4  byte enables.
REQ-014 mem_ack  input  1  bus completion, one cycle.
REQ-015 mem_rdata  input  32  bus read data, valid with mem_ack.
REQ-016 ReadData  output  32  load result to writeback.
REQ-017 StallM  output  1  freeze pipeline stages M and earlier.
REQ-018 MemDone  output  1  one-cycle pulse, access completed.
REQ-019 AlignFault  output  1  one-cycle pulse, misaligned word access.
REQ-020 BusFault  output  1  one-cycle pulse, timeout abort.

Function
REQ-021 FSM states IDLE, REQ, DONE; IDLE->REQ on MemReqM and aligned; REQ->DONE on mem_ack or timeout; DONE->IDLE unconditionally.
REQ-022 Aligned = MByteM or ALUOutM[1:0]==0.
REQ-023 In IDLE with MemReqM and not aligned: AlignFault=1 that cycle, StallM=0, no bus transaction, stays IDLE.
REQ-024 On IDLE->REQ: register we, byte flag, address, be, wdata; bus outputs driven from registers only.
REQ-025 mem_req = (state==REQ); mem_we, mem_addr, mem_be, mem_wdata stable throughout REQ.
REQ-026 Word access: mem_be=4'b1111, mem_wdata=WriteDataM.
REQ-027 Byte access: mem_be = 4'b0001 << addr[1:0]; mem_wdata = WriteDataM[7:0] replicated to all four lanes.
REQ-028 Loads: on mem_ack in REQ, ReadData <= word (mem_rdata) or byte lane addr[1:0] zero-extended to 32 bits.
REQ-029 Stores never modify ReadData; ReadData holds until next completed load.
REQ-030 StallM = (IDLE and MemReqM and aligned) or state==REQ; 0 in DONE so pipeline advances at end of DONE.
REQ-031 MemDone=1 only in DONE after ack; BusFault=1 only in DONE after timeout; never both.
REQ-032 DONE ignores MemReqM (same held instruction not re-issued).
REQ-033 Timeout counter clears on entering REQ, increments each REQ cycle without ack; abort when count reaches TIMEOUT; ack in the TIMEOUT-th cycle counts as success.
REQ-034 mem_ack outside REQ ignored; mem_rdata ignored without mem_ack.
REQ-035 Minimum latency: request cycle, one REQ cycle with ack, DONE = 3 cycles; StallM high 2 cycles.

Reset
REQ-036 Reset: state=IDLE, counter=0, all registered bus fields=0, ReadData=0, mem_req/MemDone/AlignFault/BusFault=0.
REQ-037 Reset during REQ: mem_req low next cycle, no MemDone/BusFault, pending access discarded.
REQ-038 Reset dominates MemReqM and mem_ack in the same cycle.

Verification
REQ-039 Word load addr 0x100, ack on first REQ cycle, rdata 0xCAFEBABE -> mem_be 1111, mem_addr 0x100, ReadData 0xCAFEBABE in DONE, MemDone 1 cycle, StallM 2 cycles.
REQ-040 Byte store addr 0x203, data 0x123456AB -> mem_be 1000, mem_wdata 0xABABABAB, mem_addr 0x200, ReadData unchanged.
REQ-041 Byte load addr 0x302, rdata 0x11223344, ack after 5 cycles -> ReadData 0x00000022, mem_req held 5 cycles, StallM 6 cycles.
REQ-042 Word load addr 0x101 -> AlignFault 1 cycle, mem_req never asserted, StallM 0.
REQ-043 TIMEOUT=16, no ack -> mem_req 16 cycles, BusFault pulse, ReadData unchanged; ack on 16th cycle instead -> MemDone.
REQ-044 Reset asserted on 3rd REQ cycle -> IDLE, mem_req 0 next cycle, all outputs at reset values, late ack ignored.
